cmp_hold_filter: RTL and testbench
==================================

Name: cmp_hold_filter

Overview:
- Registered, parametrised magnitude comparator for N-bit operands.
- Compares two operands a and b and reports a one-hot result: 3'b001 a<b, 3'b010 a>b, 3'b100 a==b.
- A persistence filter follows the compare stage. A new relation must be seen on HOLD consecutive valid samples before the filtered output changes, so single-sample glitches are rejected.
- Sits between sampled data sources (ADC/counter/switch paths) and control logic that needs a stable, debounced ordering decision.

Parameters:
- WIDTH, 8: operand width in bits, >=1.
- SIGNED, 0: 0 = unsigned compare, 1 = two's-complement compare.
- HOLD, 3: consecutive agreeing valid samples needed to change the filtered output, >=1.
- REJ_W, 8: width of the saturating rejected-glitch counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  a/b sample valid this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- clear  in  1  synchronous filter flush; returns to IDLE.
- q_raw  out  3  registered unfiltered one-hot compare of last valid sample.
- raw_valid  out  1  high one cycle after each accepted in_valid.
- q  out  3  filtered one-hot result; 3'b000 = no result yet.
- q_valid  out  1  high while q holds a result (STABLE or PENDING).
- changed  out  1  one-cycle pulse when q takes a new value, including the first result.
- rejected  out  REJ_W  saturating count of aborted pending changes.

Behaviour:
- Reset: rst_n=0 at a clock edge forces all outputs to 0: q_raw=000, raw_valid=0, q=000, q_valid=0, changed=0, rejected=0. Internal state goes to IDLE with cnt=0. Reset overrides clear and in_valid; mid-operation reset discards pending state.
- Compare stage, latency 1:
  - On in_valid & ~clear: q_raw <= compare(a,b) and raw_valid <= 1. Otherwise raw_valid <= 0 and q_raw holds.
  - SIGNED=1 treats the MSB as sign. Exactly one bit of q_raw is set after the first sample.
- Filter stage acts only on cycles with raw_valid=1. Internal registers: cand (3b), cnt (width $clog2(HOLD+1)). changed defaults to 0 each cycle.
  - IDLE: on raw_valid, q <= q_raw, changed <= 1, go to STABLE. In-to-q latency is 2 cycles.
  - STABLE, q_raw==q: stay, cnt=0.
  - STABLE, q_raw!=q, HOLD==1: q <= q_raw, changed <= 1, stay.
  - STABLE, q_raw!=q, HOLD>1: cand <= q_raw, cnt <= 1, go to PENDING.
  - PENDING, q_raw==cand: if cnt+1==HOLD then q <= cand, changed <= 1, cnt <= 0, go to STABLE; else cnt <= cnt+1.
  - PENDING, q_raw==q: glitch rejected. rejected <= rejected+1 (saturates at 2^REJ_W-1), cnt <= 0, go to STABLE.
  - PENDING, q_raw is the third code: cand <= q_raw, cnt <= 1, stay in PENDING, no reject count.
- Gaps (raw_valid=0) never advance or reset cnt; state and q hold.
- clear:
  - Next edge: state=IDLE, q=000, q_valid=0, cnt=0, raw_valid=0.
  - A simultaneous in_valid sample is discarded.
  - q_raw and rejected are NOT cleared.
  - changed is not pulsed by clear.
- q_valid = (state != IDLE), registered alongside q.

Decomposition:
- Shared package cmp_pkg holds:
  - result codes CMP_NONE=3'b000, CMP_LT=3'b001, CMP_GT=3'b010, CMP_EQ=3'b100;
  - filter state encoding IDLE/STABLE/PENDING.
- One natural sub-module: cmp_core, a purely combinational WIDTH/SIGNED compare that returns the one-hot code. It is reused by later comparator blocks.
- Top-level cmp_hold_filter holds the input register, FSM, counters and output registers.

Test Plan:
- Reset: hold rst_n=0 two cycles with in_valid=1, a=5, b=9 -> all outputs 0 throughout. First edge after release with in_valid=1 -> raw_valid=1, q_raw=001.
- First result and equality (WIDTH=8, HOLD=3):
  - a=5, b=9 single valid -> q_raw=001 at +1; q=001, changed=1 for one cycle and q_valid=1 at +2.
  - Then a=b=8'h80 for three valid cycles -> q=100 after the third, exactly one changed pulse.
- Glitch reject: stable q=001; feed a=20, b=9 twice then a=5, b=9 -> q stays 001, rejected=1, no changed pulse. Same stimulus with three GT samples -> q=010.
- Signed mode: a=8'hFF, b=8'h01 -> SIGNED=1 gives q_raw=001; SIGNED=0 gives q_raw=010.
- Gaps and third code:
  - GT, idle 4 cycles, GT, idle, GT -> q switches 001->010 on the third valid sample.
  - GT, GT, EQ, EQ, EQ -> q=100 after the fifth sample; rejected unchanged.
- Clear and saturation:
  - clear=1 with in_valid=1 -> next cycle q=000, q_valid=0, raw_valid=0. Next valid a=1, b=2 -> q=001 two cycles later.
  - 300 aborted glitches with REJ_W=8 -> rejected=255.

Source files
------------

// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the comparator family:
//   cmp_code_t     - one-hot ordering result (NONE / LT / GT / EQ)
//   filt_state_t   - persistence-filter state encoding (IDLE / STABLE / PENDING)
// ---------------------------------------------------------------------------
package cmp_pkg;

    typedef enum logic [2:0] {
        CMP_NONE = 3'b000,
        CMP_LT   = 3'b001,
        CMP_GT   = 3'b010,
        CMP_EQ   = 3'b100
    } cmp_code_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STABLE  = 2'd1,
        PENDING = 2'd2
    } filt_state_t;

endpackage

// File: rtl/cmp_hold_filter_if.sv
// ---------------------------------------------------------------------------
// cmp_hold_filter_if
// Bundles the sample inputs and filtered results of cmp_hold_filter.
//   in_valid, a, b, clear          - sample side (driven by master)
//   q_raw, raw_valid               - registered unfiltered compare
//   q, q_valid, changed, rejected  - persistence-filtered result and status
// Modports: master = data source / consumer, slave = the filter block.
// ---------------------------------------------------------------------------
interface cmp_hold_filter_if #(
    parameter int WIDTH = 8,
    parameter int REJ_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clear;
    logic [2:0]       q_raw;
    logic             raw_valid;
    logic [2:0]       q;
    logic             q_valid;
    logic             changed;
    logic [REJ_W-1:0] rejected;

    modport master (
        output in_valid, a, b, clear,
        input  q_raw, raw_valid, q, q_valid, changed, rejected
    );

    modport slave (
        input  in_valid, a, b, clear,
        output q_raw, raw_valid, q, q_valid, changed, rejected
    );
endinterface

// File: rtl/cmp_core.sv
// ---------------------------------------------------------------------------
// cmp_core
// Purely combinational magnitude compare returning a one-hot code.
//   a, b  in  WIDTH  operands (two's complement when SIGNED != 0)
//   code  out 3      CMP_LT / CMP_GT / CMP_EQ
// ---------------------------------------------------------------------------
module cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_code_t        code
);

    logic a_lt_b;

    always_comb begin
        if (SIGNED != 0) a_lt_b = ($signed(a) < $signed(b));
        else             a_lt_b = (a < b);

        if (a == b)      code = CMP_EQ;
        else if (a_lt_b) code = CMP_LT;
        else             code = CMP_GT;
    end

endmodule

// File: rtl/cmp_hold_filter.sv
// ---------------------------------------------------------------------------
// cmp_hold_filter
// Registered magnitude comparator followed by a persistence filter: a new
// ordering must be seen on HOLD consecutive valid samples before q changes.
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous active-low reset
//   bus    slave modport of cmp_hold_filter_if:
//            in_valid/a/b/clear in; q_raw/raw_valid/q/q_valid/changed/rejected out
// ---------------------------------------------------------------------------
module cmp_hold_filter
    import cmp_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0,
    parameter int HOLD   = 3,
    parameter int REJ_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    cmp_hold_filter_if.slave   bus
);

    localparam int CNT_W = $clog2(HOLD + 1);
    // cnt holds the number of agreeing samples already seen for cand; the
    // sample that makes it HOLD commits, so compare against HOLD-1.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD - 1);

    // ---------------- compare stage ----------------
    cmp_code_t raw_code;
    cmp_code_t q_raw_r;
    logic      raw_valid_r;
    logic      accept;

    cmp_core #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_core (
        .a    (bus.a),
        .b    (bus.b),
        .code (raw_code)
    );

    // A sample arriving together with clear is discarded.
    assign accept = bus.in_valid & ~bus.clear;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_raw_r     <= CMP_NONE;
            raw_valid_r <= 1'b0;
        end else begin
            raw_valid_r <= accept;
            if (accept) q_raw_r <= raw_code;
        end
    end

    // ---------------- persistence filter ----------------
    filt_state_t      state_r,    state_n;
    cmp_code_t        cand_r,     cand_n;
    logic [CNT_W-1:0] cnt_r,      cnt_n;
    cmp_code_t        q_r,        q_n;
    logic             q_valid_r,  q_valid_n;
    logic             changed_r,  changed_n;
    logic [REJ_W-1:0] rejected_r, rejected_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cand_r     <= CMP_NONE;
            cnt_r      <= '0;
            q_r        <= CMP_NONE;
            q_valid_r  <= 1'b0;
            changed_r  <= 1'b0;
            rejected_r <= '0;
        end else begin
            state_r    <= state_n;
            cand_r     <= cand_n;
            cnt_r      <= cnt_n;
            q_r        <= q_n;
            q_valid_r  <= q_valid_n;
            changed_r  <= changed_n;
            rejected_r <= rejected_n;
        end
    end

    // NOTE: every next-state variable gets a default before any branch, so
    // no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n    = state_r;
        cand_n     = cand_r;
        cnt_n      = cnt_r;
        q_n        = q_r;
        changed_n  = 1'b0;
        rejected_n = rejected_r;

        if (bus.clear) begin
            state_n = IDLE;
            q_n     = CMP_NONE;
            cnt_n   = '0;
        end else if (raw_valid_r) begin
            unique case (state_r)
                IDLE: begin
                    q_n       = q_raw_r;
                    changed_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = STABLE;
                end
                STABLE: begin
                    if (q_raw_r == q_r) begin
                        cnt_n = '0;
                    end else if (HOLD == 1) begin
                        q_n       = q_raw_r;
                        changed_n = 1'b1;
                    end else begin
                        cand_n  = q_raw_r;
                        cnt_n   = CNT_W'(1);
                        state_n = PENDING;
                    end
                end
                PENDING: begin
                    if (q_raw_r == cand_r) begin
                        if (cnt_r == LAST_CNT) begin
                            q_n       = cand_r;
                            changed_n = 1'b1;
                            cnt_n     = '0;
                            state_n   = STABLE;
                        end else begin
                            cnt_n = cnt_r + CNT_W'(1);
                        end
                    end else if (q_raw_r == q_r) begin
                        // Relation fell back before persisting: a glitch.
                        if (rejected_r != '1) rejected_n = rejected_r + REJ_W'(1);
                        cnt_n   = '0;
                        state_n = STABLE;
                    end else begin
                        // Third code: restart persistence on the new candidate.
                        cand_n = q_raw_r;
                        cnt_n  = CNT_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end

        q_valid_n = (state_n != IDLE);
    end

    assign bus.q_raw     = q_raw_r;
    assign bus.raw_valid = raw_valid_r;
    assign bus.q         = q_r;
    assign bus.q_valid   = q_valid_r;
    assign bus.changed   = changed_r;
    assign bus.rejected  = rejected_r;

endmodule

// File: tb/tb_cmp_hold_filter.sv
// ---------------------------------------------------------------------------
// tb_cmp_hold_filter
// Directed bench for cmp_hold_filter. Main DUT: WIDTH=8, unsigned, HOLD=3.
// Two companions share its inputs: a signed copy and a HOLD=1 copy.
// ---------------------------------------------------------------------------
module tb_cmp_hold_filter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cmp_hold_filter_if #(.WIDTH(8), .REJ_W(8)) bus   ();
    cmp_hold_filter_if #(.WIDTH(8), .REJ_W(8)) bus_s ();
    cmp_hold_filter_if #(.WIDTH(8), .REJ_W(8)) bus_h ();

    assign bus_s.in_valid = bus.in_valid;
    assign bus_s.a        = bus.a;
    assign bus_s.b        = bus.b;
    assign bus_s.clear    = bus.clear;
    assign bus_h.in_valid = bus.in_valid;
    assign bus_h.a        = bus.a;
    assign bus_h.b        = bus.b;
    assign bus_h.clear    = bus.clear;

    cmp_hold_filter #(.WIDTH(8), .SIGNED(0), .HOLD(3), .REJ_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    cmp_hold_filter #(.WIDTH(8), .SIGNED(1), .HOLD(3), .REJ_W(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s));
    cmp_hold_filter #(.WIDTH(8), .SIGNED(0), .HOLD(1), .REJ_W(8)) dut_h (
        .clk(clk), .rst_n(rst_n), .bus(bus_h));

    int errors  = 0;
    int checks  = 0;
    int chg_cnt = 0;

    // Drive one sample, let one rising edge pass, observe on the falling edge.
    task automatic step(input logic v, input logic [7:0] av, input logic [7:0] bv);
        bus.in_valid = v;
        bus.a        = av;
        bus.b        = bv;
        @(posedge clk);
        @(negedge clk);
        if (bus.changed === 1'b1) chg_cnt++;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        bus.clear = 1'b0;
        step(1'b0, 8'd0, 8'd0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 8'd5, 8'd9);
            checks++;
            if ({bus.q_raw, bus.raw_valid, bus.q, bus.q_valid, bus.changed, bus.rejected} !== 17'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got q_raw=%b raw_valid=%b q=%b q_valid=%b changed=%b rejected=%0d expected all 0",
                         i, bus.q_raw, bus.raw_valid, bus.q, bus.q_valid, bus.changed, bus.rejected);
            end
        end
        rst_n = 1'b1;
        step(1'b1, 8'd5, 8'd9);
        checks++;
        if (bus.raw_valid !== 1'b1) begin errors++; $display("FAIL reset_release_raw_valid: got %b expected 1", bus.raw_valid); end
        checks++;
        if (bus.q_raw !== 3'b001) begin errors++; $display("FAIL reset_release_q_raw: got %b expected 001", bus.q_raw); end
        step(1'b0, 8'd0, 8'd0);
    endtask

    task automatic test_first_and_equal();
        do_reset();
        step(1'b1, 8'd5, 8'd9);
        checks++;
        if (bus.q_raw !== 3'b001 || bus.raw_valid !== 1'b1 || bus.q !== 3'b000) begin
            errors++;
            $display("FAIL first_plus1: got q_raw=%b raw_valid=%b q=%b expected 001 1 000", bus.q_raw, bus.raw_valid, bus.q);
        end
        step(1'b0, 8'd0, 8'd0);
        checks++;
        if (bus.q !== 3'b001 || bus.changed !== 1'b1 || bus.q_valid !== 1'b1 || bus.raw_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_plus2: got q=%b changed=%b q_valid=%b raw_valid=%b expected 001 1 1 0",
                     bus.q, bus.changed, bus.q_valid, bus.raw_valid);
        end
        step(1'b0, 8'd0, 8'd0);
        checks++;
        if (bus.changed !== 1'b0 || bus.q !== 3'b001) begin
            errors++; $display("FAIL first_pulse_width: got changed=%b q=%b expected 0 001", bus.changed, bus.q);
        end
        chg_cnt = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 8'h80, 8'h80);
        checks++;
        if (bus.q !== 3'b001) begin errors++; $display("FAIL eq_not_early: got %b expected 001", bus.q); end
        step(1'b0, 8'd0, 8'd0);
        checks++;
        if (bus.q !== 3'b100) begin errors++; $display("FAIL eq_commit: got %b expected 100", bus.q); end
        step(1'b0, 8'd0, 8'd0);
        checks++;
        if (chg_cnt != 1) begin errors++; $display("FAIL eq_changed_count: got %0d expected 1", chg_cnt); end
    endtask

    task automatic test_glitch_reject();
        do_reset();
        step(1'b1, 8'd5, 8'd9);
        step(1'b0, 8'd0, 8'd0);
        chg_cnt = 0;
        step(1'b1, 8'd20, 8'd9);
        step(1'b1, 8'd20, 8'd9);
        checks++;
        if (bus_h.q !== 3'b010 || bus_h.changed !== 1'b1) begin
            errors++; $display("FAIL hold1_immediate: got q=%b changed=%b expected 010 1", bus_h.q, bus_h.changed);
        end
        step(1'b1, 8'd5, 8'd9);
        step(1'b0, 8'd0, 8'd0);
        step(1'b0, 8'd0, 8'd0);
        checks++;
        if (bus.q !== 3'b001) begin errors++; $display("FAIL glitch_q_held: got %b expected 001", bus.q); end
        checks++;
        if (bus.rejected !== 8'd1) begin errors++; $display("FAIL glitch_rejected: got %0d expected 1", bus.rejected); end
        checks++;
        if (chg_cnt != 0) begin errors++; $display("FAIL glitch_no_changed: got %0d expected 0", chg_cnt); end
        for (int i = 0; i < 3; i++) step(1'b1, 8'd20, 8'd9);
        step(1'b0, 8'd0, 8'd0);
        checks++;
        if (bus.q !== 3'b010 || bus.rejected !== 8'd1) begin
            errors++; $display("FAIL gt_persist: got q=%b rejected=%0d expected 010 1", bus.q, bus.rejected);
        end
    endtask

    task automatic test_signed();
        do_reset();
        step(1'b1, 8'hFF, 8'h01);
        checks++;
        if (bus.q_raw !== 3'b010) begin errors++; $display("FAIL unsigned_ff_01: got %b expected 010", bus.q_raw); end
        checks++;
        if (bus_s.q_raw !== 3'b001) begin errors++; $display("FAIL signed_ff_01: got %b expected 001", bus_s.q_raw); end
        step(1'b1, 8'h80, 8'h7F);
        checks++;
        if (bus.q_raw !== 3'b010 || bus_s.q_raw !== 3'b001) begin
            errors++; $display("FAIL extremes_80_7f: got unsigned=%b signed=%b expected 010 001", bus.q_raw, bus_s.q_raw);
        end
        step(1'b1, 8'hFE, 8'hFE);
        checks++;
        if (bus.q_raw !== 3'b100 || bus_s.q_raw !== 3'b100) begin
            errors++; $display("FAIL equal_fe: got unsigned=%b signed=%b expected 100 100", bus.q_raw, bus_s.q_raw);
        end
        step(1'b0, 8'd0, 8'd0);
    endtask

    task automatic test_gaps_third_code();
        do_reset();
        step(1'b1, 8'd5, 8'd9);
        step(1'b0, 8'd0, 8'd0);
        step(1'b1, 8'd20, 8'd9);
        for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 8'd0);
        step(1'b1, 8'd20, 8'd9);
        step(1'b0, 8'd0, 8'd0);
        step(1'b1, 8'd20, 8'd9);
        checks++;
        if (bus.q !== 3'b001) begin errors++; $display("FAIL gaps_not_early: got %b expected 001", bus.q); end
        step(1'b0, 8'd0, 8'd0);
        checks++;
        if (bus.q !== 3'b010 || bus.changed !== 1'b1) begin
            errors++; $display("FAIL gaps_commit: got q=%b changed=%b expected 010 1", bus.q, bus.changed);
        end

        do_reset();
        step(1'b1, 8'd5, 8'd9);
        step(1'b0, 8'd0, 8'd0);
        step(1'b1, 8'd20, 8'd9);
        step(1'b1, 8'd20, 8'd9);
        step(1'b1, 8'd7, 8'd7);
        step(1'b1, 8'd7, 8'd7);
        step(1'b1, 8'd7, 8'd7);
        checks++;
        if (bus.q !== 3'b001) begin errors++; $display("FAIL third_not_early: got %b expected 001", bus.q); end
        step(1'b0, 8'd0, 8'd0);
        checks++;
        if (bus.q !== 3'b100 || bus.rejected !== 8'd0) begin
            errors++; $display("FAIL third_commit: got q=%b rejected=%0d expected 100 0", bus.q, bus.rejected);
        end
    endtask

    task automatic test_clear();
        do_reset();
        step(1'b1, 8'd5, 8'd9);
        step(1'b0, 8'd0, 8'd0);
        step(1'b1, 8'd20, 8'd9);
        step(1'b1, 8'd5, 8'd9);
        step(1'b0, 8'd0, 8'd0);
        bus.clear = 1'b1;
        step(1'b1, 8'd20, 8'd9);
        bus.clear = 1'b0;
        checks++;
        if (bus.q !== 3'b000 || bus.q_valid !== 1'b0 || bus.raw_valid !== 1'b0 || bus.changed !== 1'b0) begin
            errors++;
            $display("FAIL clear_flush: got q=%b q_valid=%b raw_valid=%b changed=%b expected 000 0 0 0",
                     bus.q, bus.q_valid, bus.raw_valid, bus.changed);
        end
        checks++;
        if (bus.q_raw !== 3'b001 || bus.rejected !== 8'd1) begin
            errors++; $display("FAIL clear_keeps: got q_raw=%b rejected=%0d expected 001 1", bus.q_raw, bus.rejected);
        end
        step(1'b1, 8'd1, 8'd2);
        step(1'b0, 8'd0, 8'd0);
        checks++;
        if (bus.q !== 3'b001 || bus.q_valid !== 1'b1 || bus.changed !== 1'b1) begin
            errors++; $display("FAIL clear_restart: got q=%b q_valid=%b changed=%b expected 001 1 1", bus.q, bus.q_valid, bus.changed);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        step(1'b1, 8'd5, 8'd9);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 8'd20, 8'd9);
            step(1'b1, 8'd5, 8'd9);
        end
        step(1'b0, 8'd0, 8'd0);
        checks++;
        if (bus.rejected !== 8'd255) begin errors++; $display("FAIL reject_saturate: got %0d expected 255", bus.rejected); end
        checks++;
        if (bus.q !== 3'b001) begin errors++; $display("FAIL reject_q_held: got %b expected 001", bus.q); end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = 8'd0;
        bus.b        = 8'd0;
        bus.clear    = 1'b0;
        @(negedge clk);
        test_reset();
        test_first_and_equal();
        test_glitch_reject();
        test_signed();
        test_gaps_third_code();
        test_clear();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
